pipe_stall_ctrl: RTL and testbench

- Central stall/flush scheduler for the 5-stage pipeline.
- Combines three event sources into per-stage write enables and squash controls:
  - load-use hazards, with a configurable number of bubbles;
  - branch flushes, with the branch resolved in MEM;
  - data-memory wait freezes.
- Sits beside the pipeline registers and drives their write enables and flush inputs. Replaces ad-hoc combinational hazard logic with a sequenced controller.

---
 rtl/pipe_stall_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stall_ctrl
//  Purpose  : Central stall/flush scheduler for the 5-stage pipeline. It
//             merges load-use hazards, which insert LOAD_BUBBLES bubbles,
//             branch flushes resolved in MEM, and data-memory wait freezes.
//             From these it produces the pipeline-register write enables and
//             the squash controls.
//  Ports    : clk, rst_n           - clock / async active-low reset
//             idex_mem_read/idex_rd - load in ID/EX and its destination
//             ifid_rn/ifid_rm       - source registers of the IF/ID instr
//             actual_branch         - taken branch resolved in MEM
//             exmem_mem_req/mem_ready - data-memory handshake
//             pc_write..memwb_write - per-stage write enables
//             control_off, if_flush, ex_flush - squash controls
//             mem_timeout           - sticky fatal memory-timeout flag
//             stall_cnt/freeze_cnt/flush_cnt - statistics counters
//  Options  : STALL_STATS_EN - when defined, the three statistics counters
//             are implemented; otherwise those ports read 0.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl #(
    parameter int          LOAD_BUBBLES = 1,     // 1..7
    parameter int          MEM_TIMEOUT  = 0,     // 0 disables the timeout
    parameter logic [4:0]  ZERO_REG     = 5'd31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        idex_mem_read,
    input  logic [4:0]  idex_rd,
    input  logic [4:0]  ifid_rn,
    input  logic [4:0]  ifid_rm,
    input  logic        actual_branch,
    input  logic        exmem_mem_req,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_write,
    output logic        exmem_write,
    output logic        memwb_write,
    output logic        control_off,
    output logic        if_flush,
    output logic        ex_flush,
    output logic        mem_timeout,
    output logic [31:0] stall_cnt,
    output logic [31:0] freeze_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BUBBLE = 2'd1,
        ST_ERR    = 2'd2
    } state_t;

    localparam logic [2:0]  c_bub_init = 3'(LOAD_BUBBLES - 1);
    localparam logic [31:0] c_timeout  = 32'(MEM_TIMEOUT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_bub_cnt;
    logic [2:0]  w_bub_nxt;
    logic [31:0] r_wait_cnt;
    logic [31:0] w_wait_nxt;

    logic w_freeze;
    logic w_hazard;
    logic w_pc, w_ifid, w_idex, w_exmem, w_memwb;
    logic w_ctrl_off, w_if_flush, w_ex_flush;
    logic w_stall_ev, w_freeze_ev, w_flush_ev;

    assign w_freeze = exmem_mem_req & ~mem_ready;
    assign w_hazard = idex_mem_read & (idex_rd != ZERO_REG) &
                      ((idex_rd == ifid_rn) | (idex_rd == ifid_rm));

    // Priority: ERR > freeze > branch > BUBBLE > hazard
    always_comb begin
        w_pc        = 1'b1;
        w_ifid      = 1'b1;
        w_idex      = 1'b1;
        w_exmem     = 1'b1;
        w_memwb     = 1'b1;
        w_ctrl_off  = 1'b0;
        w_if_flush  = 1'b0;
        w_ex_flush  = 1'b0;
        w_state_nxt = r_state;
        w_bub_nxt   = r_bub_cnt;
        w_wait_nxt  = 32'd0;            // cleared on any non-freeze cycle
        w_stall_ev  = 1'b0;
        w_freeze_ev = 1'b0;
        w_flush_ev  = 1'b0;

        if (r_state == ST_ERR) begin
            w_pc    = 1'b0;
            w_ifid  = 1'b0;
            w_idex  = 1'b0;
            w_exmem = 1'b0;
            w_memwb = 1'b0;
        end else if (w_freeze) begin
            // Whole pipe holds; state and bubble count are preserved.
            w_pc        = 1'b0;
            w_ifid      = 1'b0;
            w_idex      = 1'b0;
            w_exmem     = 1'b0;
            w_memwb     = 1'b0;
            w_freeze_ev = 1'b1;
            w_wait_nxt  = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + 32'd1;
            if ((c_timeout != 32'd0) && (w_wait_nxt == c_timeout))
                w_state_nxt = ST_ERR;
        end else if (actual_branch) begin
            // Squashes the hazard-causing instructions, so pending bubbles go.
            w_if_flush  = 1'b1;
            w_ex_flush  = 1'b1;
            w_ctrl_off  = 1'b1;
            w_flush_ev  = 1'b1;
            w_bub_nxt   = 3'd0;
            w_state_nxt = ST_RUN;
        end else if (r_state == ST_BUBBLE) begin
            // Load already left ID/EX; sequencing is driven by the count only.
            w_pc       = 1'b0;
            w_ifid     = 1'b0;
            w_ctrl_off = 1'b1;
            w_stall_ev = 1'b1;
            w_bub_nxt  = r_bub_cnt - 3'd1;
            if (r_bub_cnt == 3'd1)
                w_state_nxt = ST_RUN;
        end else if (w_hazard) begin
            // First bubble is inserted in the detection cycle itself.
            w_pc       = 1'b0;
            w_ifid     = 1'b0;
            w_ctrl_off = 1'b1;
            w_stall_ev = 1'b1;
            if (LOAD_BUBBLES > 1) begin
                w_state_nxt = ST_BUBBLE;
                w_bub_nxt   = c_bub_init;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_bub_cnt  <= 3'd0;
            r_wait_cnt <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_bub_cnt  <= w_bub_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // Everything is forced low while reset is asserted, enables included.
    assign pc_write    = rst_n & w_pc;
    assign ifid_write  = rst_n & w_ifid;
    assign idex_write  = rst_n & w_idex;
    assign exmem_write = rst_n & w_exmem;
    assign memwb_write = rst_n & w_memwb;
    assign control_off = rst_n & w_ctrl_off;
    assign if_flush    = rst_n & w_if_flush;
    assign ex_flush    = rst_n & w_ex_flush;
    assign mem_timeout = rst_n & (r_state == ST_ERR);

`ifdef STALL_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_freeze_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt  <= 32'd0;
            r_freeze_cnt <= 32'd0;
            r_flush_cnt  <= 16'd0;
        end else begin
            if (w_stall_ev && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_freeze_ev && (r_freeze_cnt != '1))
                r_freeze_cnt <= r_freeze_cnt + 32'd1;
            if (w_flush_ev && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign freeze_cnt = r_freeze_cnt;
    assign flush_cnt  = r_flush_cnt;
`else
    logic w_unused_ev;
    assign w_unused_ev = w_stall_ev | w_freeze_ev | w_flush_ev;
    assign stall_cnt   = 32'd0;
    assign freeze_cnt  = 32'd0;
    assign flush_cnt   = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stall_ctrl
//  Purpose  : Self-checking bench for pipe_stall_ctrl. Four instances share
//             one stimulus bus: inst 0 LOAD_BUBBLES=1, inst 1 LOAD_BUBBLES=3,
//             inst 2 LOAD_BUBBLES=2, inst 3 LOAD_BUBBLES=1 / MEM_TIMEOUT=4.
//             Expected output vectors are queued per step and compared
//             mid-cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;

    // Output vector: {pc,ifid,idex,exmem,memwb, ctrl_off,if_flush,ex_flush, timeout}
    localparam logic [8:0] c_zero  = 9'b00000_000_0;
    localparam logic [8:0] c_norm  = 9'b11111_000_0;
    localparam logic [8:0] c_stall = 9'b00111_100_0;
    localparam logic [8:0] c_frz   = 9'b00000_000_0;
    localparam logic [8:0] c_br    = 9'b11111_111_0;
    localparam logic [8:0] c_err   = 9'b00000_000_1;

    logic       clk;
    logic       rst_n;
    logic       idex_mem_read;
    logic [4:0] idex_rd;
    logic [4:0] ifid_rn;
    logic [4:0] ifid_rm;
    logic       actual_branch;
    logic       exmem_mem_req;
    logic       mem_ready;

    logic [8:0]  obs [4];
    logic [31:0] sc  [4];
    logic [31:0] fc  [4];
    logic [15:0] flc [4];

    int checks = 0;
    int errors = 0;

    int         q_dut [$];
    logic [8:0] q_exp [$];
    string      q_tag [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        logic w_pc, w_ifid, w_idex, w_exmem, w_memwb, w_co, w_iff, w_exf, w_to;
        pipe_stall_ctrl #(
            .LOAD_BUBBLES (g == 1 ? 3 : (g == 2 ? 2 : 1)),
            .MEM_TIMEOUT  (g == 3 ? 4 : 0),
            .ZERO_REG     (5'd31)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .idex_mem_read (idex_mem_read),
            .idex_rd       (idex_rd),
            .ifid_rn       (ifid_rn),
            .ifid_rm       (ifid_rm),
            .actual_branch (actual_branch),
            .exmem_mem_req (exmem_mem_req),
            .mem_ready     (mem_ready),
            .pc_write      (w_pc),
            .ifid_write    (w_ifid),
            .idex_write    (w_idex),
            .exmem_write   (w_exmem),
            .memwb_write   (w_memwb),
            .control_off   (w_co),
            .if_flush      (w_iff),
            .ex_flush      (w_exf),
            .mem_timeout   (w_to),
            .stall_cnt     (sc[g]),
            .freeze_cnt    (fc[g]),
            .flush_cnt     (flc[g])
        );
        assign obs[g] = {w_pc, w_ifid, w_idex, w_exmem, w_memwb, w_co, w_iff, w_exf, w_to};
    end

    task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] rn,
                          input logic [4:0] rm, input logic br, input logic req,
                          input logic rdy);
        idex_mem_read = mr;
        idex_rd       = rd;
        ifid_rn       = rn;
        ifid_rm       = rm;
        actual_branch = br;
        exmem_mem_req = req;
        mem_ready     = rdy;
    endtask

    task automatic exp_o(input int d, input logic [8:0] e, input string tag);
        q_dut.push_back(d);
        q_exp.push_back(e);
        q_tag.push_back(tag);
    endtask

    // Compare every queued expectation at the falling edge, then move on to
    // just after the next rising edge where new inputs are driven.
    task automatic step();
        int         d;
        logic [8:0] e;
        string      t;
        @(negedge clk);
        while (q_dut.size() > 0) begin
            d = q_dut.pop_front();
            e = q_exp.pop_front();
            t = q_tag.pop_front();
            checks++;
            assert (obs[d] === e) else begin
                errors++;
                $error("FAIL %s inst%0d: observed %b expected %b", t, d, obs[d], e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) exp_o(i, c_zero, "reset");
        step();
        rst_n = 1'b1;
        set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        do_reset();
        for (int i = 0; i < 4; i++) exp_o(i, c_norm, "post_reset");
        step();

        // LOAD_BUBBLES=1: single bubble, XZR ignored, Rn match
        set_in(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0); exp_o(0, c_stall, "lb1_hazard_rm"); step();
        set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0); exp_o(0, c_norm,  "lb1_after");     step();
        set_in(1'b1, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0); exp_o(0, c_norm, "lb1_xzr");    step();
        set_in(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0); exp_o(0, c_stall, "lb1_hazard_rn"); step();
        set_in(1'b0, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0); exp_o(0, c_norm,  "lb1_no_load");   step();

        // LOAD_BUBBLES=3: three bubbles, then a back-to-back fresh hazard
        do_reset();
        set_in(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0); exp_o(1, c_stall, "lb3_b1"); step();
        set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0); exp_o(1, c_stall, "lb3_b2"); step();
        exp_o(1, c_stall, "lb3_b3"); step();
        exp_o(1, c_norm,  "lb3_end"); step();
        set_in(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0); exp_o(1, c_stall, "lb3_again_b1"); step();
        set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0); exp_o(1, c_stall, "lb3_again_b2"); step();
        exp_o(1, c_stall, "lb3_again_b3"); step();
        exp_o(1, c_norm,  "lb3_again_end"); step();

        // Branch with hazard in the same cycle, then branch during bubble 2
        set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0); exp_o(1, c_br,   "br_hazard"); step();
        set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0); exp_o(1, c_norm, "br_no_bubble"); step();
        set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0); exp_o(1, c_stall, "br_mid_b1"); step();
        set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0); exp_o(1, c_br,    "br_mid_b2"); step();
        set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0); exp_o(1, c_norm,  "br_cancelled"); step();

        // LOAD_BUBBLES=2: freeze during bubble 2 holds the sequence
        do_reset();
        set_in(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0); exp_o(2, c_stall, "lb2_b1"); step();
        set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin exp_o(2, c_frz, "lb2_freeze"); step(); end
        set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1); exp_o(2, c_stall, "lb2_b2"); step();
        set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0); exp_o(2, c_norm,  "lb2_run"); step();

        // MEM_TIMEOUT=4 boundary: ready in the 4th cycle avoids the timeout
        do_reset();
        set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin exp_o(3, c_frz, "to_bnd_freeze"); step(); end
        set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1); exp_o(3, c_norm, "to_bnd_ready"); step();
        set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin exp_o(3, c_frz, "to_bnd_refreeze"); step(); end
        set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0); exp_o(3, c_norm, "to_bnd_clear"); step();

        // MEM_TIMEOUT=4: four freeze cycles, sticky error from the fifth
        do_reset();
        set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin exp_o(3, c_frz, "to_freeze"); step(); end
        set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0); exp_o(3, c_err, "to_err"); step();
        checks++;
`ifdef STALL_STATS_EN
        assert (fc[3] === 32'd4) else begin
            errors++;
            $error("FAIL freeze_cnt: observed %0d expected %0d", fc[3], 4);
        end
`else
        assert (fc[3] === 32'd0) else begin
            errors++;
            $error("FAIL freeze_cnt: observed %0d expected %0d", fc[3], 0);
        end
`endif
        set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1); exp_o(3, c_err, "to_err_ready"); step();
        set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0); exp_o(3, c_err, "to_err_events"); step();
        do_reset();
        exp_o(3, c_norm, "to_cleared"); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
